// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU memory stage and one external master,
// with a starvation counter that forces a one-cycle grant to the external port.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  typedef enum logic {S_NORMAL, S_FORCE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_force, w_ext_own, w_hit;
  assign w_force = r_state == S_FORCE;
  // Outputs are gated by rst so an asserted reset takes effect without waiting for an edge.
  assign w_ext_own = rst && ext_req && (w_force || !cpu_req);
  assign w_hit = ext_req && !w_ext_own && r_wait_cnt == CNT_W'(STARVE_LIMIT - 1);
  assign ext_gnt = w_ext_own;
  assign cpu_stall = rst && w_force && ext_req && cpu_req;
  assign mem_a = w_ext_own ? ext_addr : cpu_addr;
  assign mem_wd = w_ext_own ? ext_wdata : cpu_wdata;
  assign mem_we = rst && (w_ext_own ? ext_we : cpu_we && cpu_req);
  assign cpu_rdata = mem_rd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_NORMAL;
      r_wait_cnt <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata <= '0;
    end else begin
      r_state <= w_hit ? S_FORCE : S_NORMAL;
      r_wait_cnt <= (!ext_req || w_ext_own || w_hit) ? '0 : r_wait_cnt + 1'b1;
      ext_rvalid <= w_ext_own && !ext_we;
      if (w_ext_own && !ext_we) ext_rdata <= mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed tests of the data-memory arbiter with STARVE_LIMIT=4 and a small memory model.
module tb_dmem_arbiter;
  logic clk = 0, rst = 0;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic [31:0] cpu_rdata, ext_rdata, mem_a, mem_wd, mem_rd;
  logic cpu_stall, ext_gnt, ext_rvalid, mem_we;
  logic [31:0] mem [0:255];
  int total = 0, bad = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ext_req(ext_req),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h5;
    ext_req = 1; ext_we = 1; ext_addr = 32'h200; ext_wdata = 32'h6;
    step; step; #2;
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", ext_gnt); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we); end
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", ext_rvalid); end
    total++; if (ext_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", ext_rdata); end
    total++; if (mem_a !== 32'h100) begin bad++; $display("FAIL reset_addr got=%h want=100", mem_a); end
    rst = 1; cpu_we = 0; ext_we = 0; #1;
    total++; if (ext_gnt !== 1'b0 || mem_a !== 32'h100) begin bad++; $display("FAIL post_reset_owner gnt=%b addr=%h want gnt=0 addr=100", ext_gnt, mem_a); end
    step; ext_req = 0; cpu_req = 0; step;
  endtask

  task automatic test_free_slot;
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hDEADBEEF; #2;
    total++; if (ext_gnt !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL free_write gnt=%b we=%b want 1 1", ext_gnt, mem_we); end
    total++; if (mem_a !== 32'h40 || mem_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL free_write_bus a=%h wd=%h want 40 deadbeef", mem_a, mem_wd); end
    step;
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL write_no_rvalid got=%b want=0", ext_rvalid); end
    ext_we = 0; #2;
    total++; if (ext_gnt !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL free_read gnt=%b we=%b want 1 0", ext_gnt, mem_we); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rdata got=%h want=deadbeef", cpu_rdata); end
    step; ext_req = 0; #2;
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_return v=%b d=%h want 1 deadbeef", ext_rvalid, ext_rdata); end
    step;
    total++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_hold v=%b d=%h want 0 deadbeef", ext_rvalid, ext_rdata); end
  endtask

  task automatic test_back_to_back;
    ext_req = 1; ext_we = 1; ext_addr = 32'h44; ext_wdata = 32'hCAFEF00D; step;
    ext_we = 0; ext_addr = 32'h40; step;
    ext_addr = 32'h44; #2;
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_first v=%b d=%h want 1 deadbeef", ext_rvalid, ext_rdata); end
    step; ext_req = 0; #2;
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_second v=%b d=%h want 1 cafef00d", ext_rvalid, ext_rdata); end
    step;
  endtask

  task automatic test_starvation;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL starve_cyc%0d gnt=%b stall=%b want 0 0", i, ext_gnt, cpu_stall); end
      step;
    end
    #2;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_a !== 32'h44) begin bad++; $display("FAIL starve_force gnt=%b stall=%b a=%h want 1 1 44", ext_gnt, cpu_stall, mem_a); end
    step; ext_req = 0; #2;
    total++; if (cpu_stall !== 1'b0 || dut.r_wait_cnt !== 8'd0 || mem_a !== 32'h40) begin bad++; $display("FAIL starve_after stall=%b cnt=%0d a=%h want 0 0 40", cpu_stall, dut.r_wait_cnt, mem_a); end
    total++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL starve_rdata v=%b d=%h want 1 cafef00d", ext_rvalid, ext_rdata); end
    cpu_req = 0; step;
  endtask

  task automatic test_force_store;
    ext_req = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h0; step;
    ext_addr = 32'h84; step;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; ext_wdata = 32'h22;
    for (int i = 0; i < 4; i++) step;
    cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h11; #2;
    total++; if (cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_a !== 32'h84 || mem_wd !== 32'h22) begin bad++; $display("FAIL force_store_bus stall=%b we=%b a=%h wd=%h want 1 1 84 22", cpu_stall, mem_we, mem_a, mem_wd); end
    step; ext_req = 0; #2;
    total++; if (mem[32] !== 32'h0 || mem[33] !== 32'h22) begin bad++; $display("FAIL force_store_mem m80=%h m84=%h want 0 22", mem[32], mem[33]); end
    total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h80) begin bad++; $display("FAIL reissue stall=%b we=%b a=%h want 0 1 80", cpu_stall, mem_we, mem_a); end
    step; cpu_req = 0; cpu_we = 0; ext_req = 1; ext_we = 0; ext_addr = 32'h80; step;
    ext_addr = 32'h84; #2;
    total++; if (ext_rdata !== 32'h11) begin bad++; $display("FAIL readback_80 got=%h want=11", ext_rdata); end
    step; ext_req = 0; #2;
    total++; if (ext_rdata !== 32'h22) begin bad++; $display("FAIL readback_84 got=%h want=22", ext_rdata); end
    step;
  endtask

  task automatic test_withdrawn;
    cpu_req = 1; cpu_addr = 32'h40; ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    step; step; ext_req = 0; step; #2;
    total++; if (dut.r_wait_cnt !== 8'd0) begin bad++; $display("FAIL withdraw_cnt got=%0d want=0", dut.r_wait_cnt); end
    ext_req = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL rewait_cyc%0d gnt=%b want=0", i, ext_gnt); end
      step;
    end
    #2;
    total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL rewait_grant gnt=%b want=1", ext_gnt); end
    step; ext_req = 0; cpu_req = 0; step;
  endtask

  task automatic test_reset_mid_force;
    cpu_req = 1; cpu_addr = 32'h40; ext_req = 1; ext_we = 0; ext_addr = 32'h44;
    for (int i = 0; i < 4; i++) step;
    #1;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1) begin bad++; $display("FAIL pre_reset_force gnt=%b stall=%b want 1 1", ext_gnt, cpu_stall); end
    rst = 0; #1;
    total++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_a !== 32'h40) begin bad++; $display("FAIL async_reset gnt=%b stall=%b a=%h want 0 0 40", ext_gnt, cpu_stall, mem_a); end
    step;
    total++; if (ext_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid_held got=%b want=0", ext_rvalid); end
    rst = 1; #2;
    total++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL post_reset_normal gnt=%b stall=%b want 0 0", ext_gnt, cpu_stall); end
    step; ext_req = 0; cpu_req = 0; step;
  endtask

  initial begin
    test_reset;
    test_free_slot;
    test_back_to_back;
    test_starvation;
    test_force_store;
    test_withdrawn;
    test_reset_mid_force;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter placed between the pipeline's memory stage and the data memory. Shares the memory between the CPU memory stage (port C, default owner) and one external master such as a debug or DMA port (port X). A starvation counter and a two-state FSM bound port X's waiting time by stealing one cycle from the CPU and stalling the pipeline. Data memory semantics are unchanged: writes are synchronous on clk, reads are combinational.

## Interface
- STARVE_LIMIT, 8: consecutive cycles port X may lose arbitration before a forced grant; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must satisfy STARVE_LIMIT ≤ 2^CNT_W − 1.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  memory-stage access this cycle (load or store)
- cpu_we  in  1  memory-stage store
- cpu_addr  in  32  memory-stage address (ALU result)
- cpu_wdata  in  32  memory-stage store data
- cpu_rdata  out  32  load data to the memory stage; equals mem_rd, combinational
- cpu_stall  out  1  freeze request for the pipeline; the current memory-stage access did not occur
- ext_req  in  1  port X request; must be held with stable we/addr/wdata until ext_gnt
- ext_we  in  1  port X write
- ext_addr  in  32  port X address
- ext_wdata  in  32  port X write data
- ext_gnt  out  1  port X access performed this cycle, combinational
- ext_rvalid  out  1  registered; ext_rdata valid, one cycle after a granted read
- ext_rdata  out  32  registered read data for port X
- mem_we  out  1  data-memory write enable
- mem_a  out  32  data-memory address
- mem_wd  out  32  data-memory write data
- mem_rd  in  32  data-memory read data, combinational from mem_a

## Operation
- **State:** FSM state ∈ {NORMAL, FORCE} and counter wait_cnt[CNT_W-1:0].
- **Owner selection, NORMAL:**
  - Port X wins when ext_req is high and cpu_req is low.
  - Otherwise the CPU owns the cycle; with no request, the idle owner is the CPU.
- **Owner selection, FORCE:**
  - Port X wins if ext_req is high.
  - cpu_stall equals cpu_req.
  - If ext_req is low in FORCE (a protocol violation), the CPU owns the cycle and cpu_stall is 0.
- **Memory drive:**
  - mem_a and mem_wd come from the owner.
  - mem_we equals owner_we AND owner_req.
  - A CPU store is never written while cpu_stall is 1.
- **Grant:** ext_gnt = 1 exactly when port X is the owner. cpu_stall is never 1 in NORMAL.
- **wait_cnt update, each posedge:**
  - Cleared to 0 if ext_req is low or ext_gnt is 1.
  - Otherwise incremented, saturating at STARVE_LIMIT−1.
- **FSM transitions:**
  - NORMAL → FORCE when ext_req=1, ext_gnt=0 and wait_cnt=STARVE_LIMIT−1; wait_cnt is cleared on that edge.
  - FORCE → NORMAL unconditionally on the next edge, so there are never two consecutive stall cycles.
- **Read return:** on a granted port X read (ext_gnt=1, ext_we=0):
  - The next edge sets ext_rvalid=1 and ext_rdata=mem_rd.
  - ext_rvalid returns to 0 on the following edge unless another read is granted.
  - ext_rdata holds its value until the next granted read.
- **Write return:** a granted port X write produces no ext_rvalid.
- **Pipeline handling:** when cpu_stall is 1, the pipeline freezes PC, IF/ID, ID/EX and EX/MEM, and injects a bubble (RegWrite=0) into MEM/WB. The held access reissues in the next cycle, which is a NORMAL cycle in which the CPU wins.

## Timing
- **Reset:**
  - While rst=0: state=NORMAL, wait_cnt=0, ext_rvalid=0, ext_rdata=0.
  - ext_gnt, cpu_stall and mem_we are forced to 0.
  - mem_a=cpu_addr, mem_wd=cpu_wdata.
  - Asserting reset mid-FORCE takes effect immediately, with no wait for an edge.
- **Latency:**
  - Port C: zero cycles, same as an unarbitrated memory stage.
  - Port X grant: 0 cycles on a free slot. Under continuous CPU traffic, the request raised in cycle t is granted in cycle t+STARVE_LIMIT.
  - Port X read data: ext_rvalid arrives 1 cycle after ext_gnt.
- **Worst-case bandwidth:** the CPU loses at most 1 cycle in every STARVE_LIMIT+1.
- **Back-to-back reads:** port X may issue back-to-back reads on free slots; ext_rvalid then stays high continuously with new data each cycle.
- **Simultaneous requests in FORCE:** when both ports request the same address in a FORCE cycle, only the port X access happens. The CPU's access reissues the next cycle and observes any port X write.

## Test plan
- **Reset:** hold rst=0 with cpu_req=ext_req=1 → ext_gnt=cpu_stall=mem_we=ext_rvalid=0 and ext_rdata=0. After release, the CPU owns the first cycle.
- **Free-slot write then read:** cpu_req=0; port X writes 0xDEADBEEF to 0x40 → ext_gnt=1 and mem_we=1 in the same cycle. Then read 0x40 → ext_rvalid=1 one cycle later with ext_rdata=0xDEADBEEF.
- **Starvation (STARVE_LIMIT=4):** cpu_req=1 every cycle and ext_req raised at cycle 0 → ext_gnt=0 in cycles 0–3. Cycle 4: ext_gnt=1 and cpu_stall=1. Cycle 5: cpu_stall=0 and wait_cnt=0.
- **CPU store during a forced slot:** CPU stores 0x11 to 0x80 while port X writes 0x22 to 0x84 in FORCE → only 0x84 is written in that cycle. The next cycle writes 0x80=0x11; a later read of both addresses returns 0x11 and 0x22.
- **Request withdrawn:** ext_req dropped after 2 losing cycles → wait_cnt=0 and no FORCE. Re-raised → a full STARVE_LIMIT wait applies again.
- **Reset mid-FORCE:** assert rst=0 during the FORCE cycle with a read granted → cpu_stall and ext_gnt drop asynchronously, ext_rvalid stays 0, and the state is NORMAL after release.
